// File: rtl/rx_lbuf_pkg.sv
// rx_lbuf_pkg
//   Shared definitions for the RX large-buffer ring hand-out block:
//   FSM state encoding, the bit position above which an lbuf address
//   needs 64-bit addressing, and default geometry.
package rx_lbuf_pkg;

  localparam int unsigned DEF_NUM_LBUF = 2;
  localparam int unsigned DEF_ADDR_W   = 64;

  // Any set bit at or above this position means the DMA must use
  // 64-bit addressing for the lbuf.
  localparam int unsigned ADDR64_LSB   = 32;

  // One-hot so that the two unused codes are detectable as illegal.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_BUSY = 2'b10
  } lbuf_state_e;

endpackage

// File: rtl/rx_lbuf_ring_gv.sv
// rx_lbuf_ring_gv
//   Hands host-posted large buffers (lbufs) to the RX packet writer one at
//   a time, in strict ring order 0, 1, ..., NUM_LBUF-1, 0, ...
//
//   State table
//     state   | meaning
//     ST_IDLE | tracking slot_addr[ptr]; waiting for slot_en[ptr]
//     ST_BUSY | lbuf at ptr offered to writer; waiting for lbuf_dn
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   slot_addr_i   flattened slot addresses, slot i at [i*ADDR_W +: ADDR_W]
//   slot_en_i     per-slot "posted" level from the host
//   slot_dn_o     one-cycle pulse on the slot just consumed
//   lbuf_addr_o   address of the offered lbuf
//   lbuf_en_o     offer valid (level)
//   lbuf64b_o     offered address has bits set at or above bit 32
//   lbuf_idx_o    slot index of the offered lbuf
//   lbuf_dn_i     writer finished with the offered lbuf
//   gv_cnt_o      lbufs completed since reset (wrapping)
module rx_lbuf_ring_gv
  import rx_lbuf_pkg::*;
#(
  parameter int unsigned NUM_LBUF = DEF_NUM_LBUF,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned IDX_W    = $clog2(NUM_LBUF),
  parameter int unsigned CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LBUF*ADDR_W-1:0] slot_addr_i,
  input  logic [NUM_LBUF-1:0]        slot_en_i,
  output logic [NUM_LBUF-1:0]        slot_dn_o,
  output logic [ADDR_W-1:0]          lbuf_addr_o,
  output logic                       lbuf_en_o,
  output logic                       lbuf64b_o,
  output logic [IDX_W-1:0]           lbuf_idx_o,
  input  logic                       lbuf_dn_i,
  output logic [CNT_W-1:0]           gv_cnt_o
);

  lbuf_state_e          state_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;
  logic [CNT_W-1:0]     gv_cnt_q;
  logic [CNT_W-1:0]     gv_cnt_d;
  logic [NUM_LBUF-1:0]  slot_dn_q;
  logic [NUM_LBUF-1:0]  slot_dn_d;
  logic [ADDR_W-1:0]    lbuf_addr_q;
  logic                 lbuf_en_q;
  logic                 lbuf64b_q;
  logic [IDX_W-1:0]     lbuf_idx_q;

  logic [ADDR_W-1:0]    slot_arr [NUM_LBUF];
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_64b;
  logic                 sel_en;

  for (genvar i = 0; i < NUM_LBUF; i++) begin : g_slot
    assign slot_arr[i] = slot_addr_i[i*ADDR_W +: ADDR_W];
  end

  assign sel_addr = slot_arr[ptr_q];
  assign sel_en   = slot_en_i[ptr_q];

  if (ADDR_W > ADDR64_LSB) begin : g_addr64
    assign sel_64b = |sel_addr[ADDR_W-1:ADDR64_LSB];
  end else begin : g_addr32
    assign sel_64b = 1'b0;
  end

  // NUM_LBUF is a power of two, so the pointer wraps by plain overflow.
  assign ptr_d     = ptr_q + IDX_W'(1);
  assign gv_cnt_d  = gv_cnt_q + CNT_W'(1);
  assign slot_dn_d = NUM_LBUF'(1) << ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gv_cnt_q    <= '0;
      slot_dn_q   <= '0;
      lbuf_addr_q <= '0;
      lbuf_en_q   <= 1'b0;
      lbuf64b_q   <= 1'b0;
      lbuf_idx_q  <= '0;
    end else begin
      slot_dn_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // Offer registers follow the current slot while idle so the
          // address is already captured in the cycle slot_en is seen.
          lbuf_addr_q <= sel_addr;
          lbuf64b_q   <= sel_64b;
          lbuf_idx_q  <= ptr_q;
          if (sel_en) begin
            lbuf_en_q <= 1'b1;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (lbuf_dn_i) begin
            lbuf_en_q <= 1'b0;
            slot_dn_q <= slot_dn_d;
            ptr_q     <= ptr_d;
            gv_cnt_q  <= gv_cnt_d;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          lbuf_en_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign slot_dn_o   = slot_dn_q;
  assign lbuf_addr_o = lbuf_addr_q;
  assign lbuf_en_o   = lbuf_en_q;
  assign lbuf64b_o   = lbuf64b_q;
  assign lbuf_idx_o  = lbuf_idx_q;
  assign gv_cnt_o    = gv_cnt_q;

endmodule

// File: tb/tb_rx_lbuf_ring_gv.sv
// tb_rx_lbuf_ring_gv
//   Scoreboard bench for rx_lbuf_ring_gv. The driver pushes expected offers
//   and completions computed from a ring model; a negedge monitor pops and
//   compares whenever the DUT raises lbuf_en or pulses slot_dn.
//   A second small instance covers the 32-bit address / 4-bit counter case.
module tb_rx_lbuf_ring_gv;

  localparam int N   = 4;
  localparam int AW  = 64;
  localparam int IW  = 2;
  localparam int CW  = 5;

  localparam int N2  = 2;
  localparam int AW2 = 32;
  localparam int IW2 = 1;
  localparam int CW2 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*AW-1:0]  slot_addr;
  logic [N-1:0]     slot_en;
  logic [N-1:0]     slot_dn;
  logic [AW-1:0]    lbuf_addr;
  logic             lbuf_en;
  logic             lbuf64b;
  logic [IW-1:0]    lbuf_idx;
  logic             lbuf_dn;
  logic [CW-1:0]    gv_cnt;

  logic [N2*AW2-1:0] d2_slot_addr;
  logic [N2-1:0]     d2_slot_en;
  logic [N2-1:0]     d2_slot_dn;
  logic [AW2-1:0]    d2_lbuf_addr;
  logic              d2_lbuf_en;
  logic              d2_lbuf64b;
  logic [IW2-1:0]    d2_lbuf_idx;
  logic              d2_lbuf_dn;
  logic [CW2-1:0]    d2_gv_cnt;

  rx_lbuf_ring_gv #(.NUM_LBUF(N), .ADDR_W(AW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .slot_addr_i(slot_addr), .slot_en_i(slot_en), .slot_dn_o(slot_dn),
    .lbuf_addr_o(lbuf_addr), .lbuf_en_o(lbuf_en), .lbuf64b_o(lbuf64b),
    .lbuf_idx_o(lbuf_idx), .lbuf_dn_i(lbuf_dn), .gv_cnt_o(gv_cnt)
  );

  rx_lbuf_ring_gv #(.NUM_LBUF(N2), .ADDR_W(AW2), .CNT_W(CW2)) u_dut32 (
    .clk(clk), .rst(rst),
    .slot_addr_i(d2_slot_addr), .slot_en_i(d2_slot_en), .slot_dn_o(d2_slot_dn),
    .lbuf_addr_o(d2_lbuf_addr), .lbuf_en_o(d2_lbuf_en), .lbuf64b_o(d2_lbuf64b),
    .lbuf_idx_o(d2_lbuf_idx), .lbuf_dn_i(d2_lbuf_dn), .gv_cnt_o(d2_gv_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [63:0] addr;
    int          idx;
    logic        b64;
  } offer_t;

  typedef struct {
    logic [N-1:0]  mask;
    logic [CW-1:0] cnt;
  } done_t;

  offer_t offer_q[$];
  done_t  done_q[$];

  int          ptr_m;
  int          cnt_m;
  logic [63:0] addr_m [N];
  bit          en_m   [N];

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) a[63:32] = '0;
    return a;
  endfunction

  task automatic drive_slots();
    for (int i = 0; i < N; i++) begin
      slot_addr[i*AW +: AW] = addr_m[i];
      slot_en[i]            = en_m[i];
    end
  endtask

  // ---------------- monitor ----------------
  logic   prev_en;
  offer_t cur;

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (lbuf_en && !prev_en) begin
        if (offer_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_offer: got offer idx %0d addr %0h, expected none", lbuf_idx, lbuf_addr);
        end else begin
          cur = offer_q.pop_front();
          chk("offer_addr", lbuf_addr, cur.addr);
          chk("offer_idx", 64'(lbuf_idx), 64'(cur.idx));
          chk("offer_64b", 64'(lbuf64b), 64'(cur.b64));
        end
      end else if (lbuf_en) begin
        chk("hold_addr", lbuf_addr, cur.addr);
        chk("hold_idx", 64'(lbuf_idx), 64'(cur.idx));
      end
      if (slot_dn != '0) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slot_dn: got %b, expected none", slot_dn);
        end else begin
          done_t d;
          d = done_q.pop_front();
          chk("slot_dn", 64'(slot_dn), 64'(d.mask));
          chk("gv_cnt", 64'(gv_cnt), 64'(d.cnt));
          chk("en_fall", 64'(lbuf_en), 64'd0);
        end
      end
      prev_en = lbuf_en;
    end
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+1. Posts slot ptr_m (unless already posted),
  // waits for the offer, holds, then completes it.
  task automatic do_txn(input bit forced, input logic [63:0] fa, input bit stress);
    int     k;
    int     n;
    int     stall;
    int     hold;
    offer_t o;
    done_t  d;
    k = ptr_m;
    if (!en_m[k]) begin
      stall = stress ? int'($urandom_range(0, 4)) : 0;
      if (stress) begin
        for (int j = 1; j < N; j++) begin
          int s;
          s = (k + j) % N;
          if (!en_m[s] && $urandom_range(0, 2) == 0) begin
            addr_m[s] = rand_addr();
            en_m[s]   = 1'b1;
          end
        end
      end
      drive_slots();
      if (stress && $urandom_range(0, 1) == 1) begin
        lbuf_dn = 1'b1;
        @(posedge clk); #1;
        lbuf_dn = 1'b0;
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("stall_idle", 64'(lbuf_en), 64'd0);
        @(posedge clk); #1;
      end
      addr_m[k] = forced ? fa : rand_addr();
      en_m[k]   = 1'b1;
      drive_slots();
    end
    o.addr = addr_m[k];
    o.idx  = k;
    o.b64  = (addr_m[k][63:32] != 32'd0);
    offer_q.push_back(o);

    n = 0;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      n++;
      if (lbuf_en) break;
    end
    chk("offer_latency", 64'(n), 64'd2);

    @(posedge clk); #1;
    hold = stress ? int'($urandom_range(0, 3)) : 0;
    if (stress && $urandom_range(0, 1) == 1) begin
      addr_m[k] = rand_addr();
      en_m[k]   = 1'b0;
      drive_slots();
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
    end

    lbuf_dn = 1'b1;
    cnt_m++;
    d.mask    = '0;
    d.mask[k] = 1'b1;
    d.cnt     = CW'(cnt_m % (1 << CW));
    done_q.push_back(d);
    ptr_m   = (k + 1) % N;
    en_m[k] = 1'b0;
    @(posedge clk); #1;
    lbuf_dn = 1'b0;
    drive_slots();
  endtask

  task automatic model_clear();
    ptr_m = 0;
    cnt_m = 0;
    for (int i = 0; i < N; i++) begin
      addr_m[i] = '0;
      en_m[i]   = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b1;
    lbuf_dn      = 1'b0;
    slot_addr    = {N{64'hDEAD_BEEF_1234_5678}};
    slot_en      = '1;
    d2_slot_addr = '0;
    d2_slot_en   = '0;
    d2_lbuf_dn   = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lbuf_en", 64'(lbuf_en), 64'd0);
    chk("rst_gv_cnt", 64'(gv_cnt), 64'd0);
    chk("rst_slot_dn", 64'(slot_dn), 64'd0);
    chk("rst_lbuf_addr", lbuf_addr, 64'd0);
    chk("rst_lbuf64b", 64'(lbuf64b), 64'd0);
    chk("rst_lbuf_idx", 64'(lbuf_idx), 64'd0);
    @(posedge clk); #1;
    drive_slots();
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: 32-bit then 64-bit address, then wrap back to slot 0.
    do_txn(1'b1, 64'h0000_0000_1000_0000, 1'b0);
    do_txn(1'b1, 64'h0000_0001_0000_0000, 1'b0);
    do_txn(1'b0, '0, 1'b0);
    do_txn(1'b0, '0, 1'b0);

    // Later slots posted ahead of ptr must stall, not skip.
    for (int i = 1; i < N; i++) begin
      addr_m[i] = rand_addr();
      en_m[i]   = 1'b1;
    end
    drive_slots();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("strict_order_stall", 64'(lbuf_en), 64'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) do_txn(1'b0, '0, 1'b0);

    // Randomized phase; enough completions to wrap the 5-bit counter.
    for (int t = 0; t < 60; t++) do_txn(1'b0, '0, 1'b1);

    // Reset while busy on slot 1.
    while (ptr_m != 1) do_txn(1'b0, '0, 1'b0);
    begin
      offer_t o;
      addr_m[1] = 64'hFFFF_0000_AAAA_5555;
      en_m[1]   = 1'b1;
      drive_slots();
      o.addr = addr_m[1];
      o.idx  = 1;
      o.b64  = 1'b1;
      offer_q.push_back(o);
      n = 0;
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        n++;
        if (lbuf_en) break;
      end
      chk("rst_busy_offer_latency", 64'(n), 64'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      model_clear();
      drive_slots();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy_lbuf_en", 64'(lbuf_en), 64'd0);
      chk("rst_busy_gv_cnt", 64'(gv_cnt), 64'd0);
      chk("rst_busy_lbuf_idx", 64'(lbuf_idx), 64'd0);
      chk("rst_busy_lbuf_addr", lbuf_addr, 64'd0);
      chk("rst_busy_slot_dn", 64'(slot_dn), 64'd0);
      @(posedge clk); #1;
    end
    do_txn(1'b0, '0, 1'b0);
    do_txn(1'b0, '0, 1'b0);

    repeat (4) @(posedge clk);
    chk("offer_q_drained", 64'(offer_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);

    // 32-bit address, 4-bit counter instance: 17 completions.
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      int          k;
      logic [31:0] a;
      k = i % N2;
      a = $urandom;
      d2_slot_addr[k*AW2 +: AW2] = a;
      d2_slot_en[k] = 1'b1;
      n = 0;
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        n++;
        if (d2_lbuf_en) break;
      end
      chk("d2_offer_latency", 64'(n), 64'd2);
      chk("d2_lbuf_addr", 64'(d2_lbuf_addr), 64'(a));
      chk("d2_lbuf_idx", 64'(d2_lbuf_idx), 64'(k));
      chk("d2_lbuf64b", 64'(d2_lbuf64b), 64'd0);
      @(posedge clk); #1;
      d2_lbuf_dn    = 1'b1;
      d2_slot_en[k] = 1'b0;
      @(posedge clk); #1;
      d2_lbuf_dn = 1'b0;
      @(negedge clk);
      chk("d2_slot_dn", 64'(d2_slot_dn), 64'(1 << k));
      chk("d2_gv_cnt", 64'(d2_gv_cnt), 64'((i + 1) % 16));
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
